// File: rtl/br_resolver.sv
// Branch resolver: evaluates EX-stage branch/jump outcome, detects mispredicts and
// sequences the fetch redirect and pipeline flush. Optional perf counters: BR_PERF_CNT_EN.
module br_resolver (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [2:0]  i_funct3,
   input  logic        i_is_jump,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_br_un,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_target,
   input  logic        i_pred_taken,
   output logic        o_redirect,
   input  logic        i_redirect_ready,
   output logic [31:0] o_redirect_pc,
   output logic        o_flush,
   output logic        o_busy,
   output logic        o_resolved,
   output logic        o_taken,
   output logic        o_illegal,
   input  logic        i_cnt_clr,
   output logic [15:0] o_br_cnt,
   output logic [15:0] o_mis_cnt
);

   // state    | meaning
   // IDLE     | ready to accept a branch/jump
   // REDIRECT | corrected PC offered to fetch, IF/ID flushed, waiting for ready
   // FLUSH    | one extra flush cycle after fetch accepted the redirect
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        resolved_q, resolved_d;
   logic        taken_q, taken_d;
   logic        illegal_q, illegal_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic accept;
   logic cond;
   logic taken;
   logic illegal;
   logic mispredict;

   assign o_br_un = i_funct3[1];

   always_comb begin
      cond    = 1'b0;
      illegal = 1'b0;
      unique case (i_funct3)
         3'b000:  cond = i_br_equal;
         3'b001:  cond = ~i_br_equal;
         3'b100,
         3'b110:  cond = i_br_less;
         3'b101,
         3'b111:  cond = ~i_br_less;
         default: illegal = ~i_is_jump;
      endcase
   end

   assign taken      = i_is_jump | cond;
   assign accept     = i_valid && (state_q == IDLE);
   assign mispredict = taken != i_pred_taken;

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      resolved_d    = accept;
      taken_d       = accept & taken;
      illegal_d     = accept & illegal;
      unique case (state_q)
         IDLE: begin
            if (accept && mispredict) begin
               state_d       = REDIRECT;
               redirect_pc_d = taken ? i_target : i_pc + 32'd4;
            end
         end
         REDIRECT: begin
            if (i_redirect_ready) state_d = FLUSH;
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         resolved_q    <= 1'b0;
         taken_q       <= 1'b0;
         illegal_q     <= 1'b0;
         redirect_pc_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         resolved_q    <= resolved_d;
         taken_q       <= taken_d;
         illegal_q     <= illegal_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Decoded straight from state so an async reset drops redirect/flush at once.
   assign o_redirect    = (state_q == REDIRECT);
   assign o_flush       = (state_q != IDLE);
   assign o_busy        = (state_q != IDLE);
   assign o_redirect_pc = redirect_pc_q;
   assign o_resolved    = resolved_q;
   assign o_taken       = taken_q;
   assign o_illegal     = illegal_q;

`ifdef BR_PERF_CNT_EN
   logic [15:0] br_cnt_q, br_cnt_d;
   logic [15:0] mis_cnt_q, mis_cnt_d;

   // Clear wins over a same-cycle increment; both counters saturate.
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (i_cnt_clr) begin
         br_cnt_d  = 16'h0;
         mis_cnt_d = 16'h0;
      end else if (accept) begin
         if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
         if (mispredict && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         br_cnt_q  <= 16'h0;
         mis_cnt_q <= 16'h0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign o_br_cnt  = br_cnt_q;
   assign o_mis_cnt = mis_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = i_cnt_clr;
   assign o_br_cnt       = 16'h0;
   assign o_mis_cnt      = 16'h0;
`endif

endmodule

// File: tb/tb_br_resolver.sv
// Self-checking bench for br_resolver: directed scenarios plus random branches
// checked against an operand-level reference model.
module tb_br_resolver;

`ifdef BR_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [2:0]  i_funct3;
   logic        i_is_jump;
   logic        i_br_less;
   logic        i_br_equal;
   logic        o_br_un;
   logic [31:0] i_pc;
   logic [31:0] i_target;
   logic        i_pred_taken;
   logic        o_redirect;
   logic        i_redirect_ready;
   logic [31:0] o_redirect_pc;
   logic        o_flush;
   logic        o_busy;
   logic        o_resolved;
   logic        o_taken;
   logic        o_illegal;
   logic        i_cnt_clr;
   logic [15:0] o_br_cnt;
   logic [15:0] o_mis_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_br   = 0;
   int exp_mis  = 0;

   br_resolver dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_funct3(i_funct3),
      .i_is_jump(i_is_jump), .i_br_less(i_br_less), .i_br_equal(i_br_equal),
      .o_br_un(o_br_un), .i_pc(i_pc), .i_target(i_target), .i_pred_taken(i_pred_taken),
      .o_redirect(o_redirect), .i_redirect_ready(i_redirect_ready),
      .o_redirect_pc(o_redirect_pc), .o_flush(o_flush), .o_busy(o_busy),
      .o_resolved(o_resolved), .o_taken(o_taken), .o_illegal(o_illegal),
      .i_cnt_clr(i_cnt_clr), .o_br_cnt(o_br_cnt), .o_mis_cnt(o_mis_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Branch semantics from the operands themselves, not from comparator flags.
   function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk_cnt(input string tag);
      chk({tag, "_brcnt"},  {16'h0, o_br_cnt},  CNT_EN ? exp_br  : 0);
      chk({tag, "_miscnt"}, {16'h0, o_mis_cnt}, CNT_EN ? exp_mis : 0);
   endtask

   // Called just after a rising edge with the DUT in IDLE; returns just after the
   // edge on which the DUT is back in IDLE (next cycle if correctly predicted).
   task automatic run_branch(input string tag, input logic [2:0] f3, input logic jmp,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic pred, input int delay, input logic poke,
                             input logic clr);
      logic        e_taken, e_ill, e_mis;
      logic [31:0] e_pc;
      e_taken = jmp || ref_cond(f3, a, b);
      e_ill   = !jmp && (f3 == 3'b010 || f3 == 3'b011);
      e_mis   = e_taken != pred;
      e_pc    = e_taken ? tgt : pc + 32'd4;
      i_valid      = 1'b1;
      i_funct3     = f3;
      i_is_jump    = jmp;
      i_br_equal   = (a == b);
      i_br_less    = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      i_pc         = pc;
      i_target     = tgt;
      i_pred_taken = pred;
      i_cnt_clr    = clr;
      i_redirect_ready = 1'b0;
      #1;
      chk({tag, "_br_un"}, {31'h0, o_br_un}, {31'h0, f3[1]});
      if (clr) begin
         exp_br  = 0;
         exp_mis = 0;
      end else begin
         if (exp_br < 65535) exp_br++;
         if (e_mis && exp_mis < 65535) exp_mis++;
      end
      @(posedge i_clk); #1;
      i_cnt_clr = 1'b0;
      if (poke) i_funct3 = 3'b010;
      else i_valid = 1'b0;
      chk({tag, "_resolved"}, {31'h0, o_resolved}, 32'd1);
      chk({tag, "_taken"},    {31'h0, o_taken},    {31'h0, e_taken});
      chk({tag, "_illegal"},  {31'h0, o_illegal},  {31'h0, e_ill});
      chk_cnt(tag);
      if (e_mis) begin
         for (int d = 0; d <= delay; d++) begin
            i_redirect_ready = (d == delay);
            chk({tag, "_redir"},   {31'h0, o_redirect}, 32'd1);
            chk({tag, "_rflush"},  {31'h0, o_flush},    32'd1);
            chk({tag, "_rbusy"},   {31'h0, o_busy},     32'd1);
            chk({tag, "_rpc"},     o_redirect_pc,       e_pc);
            if (d > 0) begin
               chk({tag, "_ign_res"}, {31'h0, o_resolved}, 32'd0);
               chk({tag, "_ign_ill"}, {31'h0, o_illegal},  32'd0);
            end
            @(posedge i_clk); #1;
         end
         i_redirect_ready = 1'b0;
         chk({tag, "_fredir"}, {31'h0, o_redirect}, 32'd0);
         chk({tag, "_fflush"}, {31'h0, o_flush},    32'd1);
         chk({tag, "_fbusy"},  {31'h0, o_busy},     32'd1);
         @(posedge i_clk); #1;
         i_valid = 1'b0;
         chk({tag, "_iflush"}, {31'h0, o_flush}, 32'd0);
         chk({tag, "_ires"},   {31'h0, o_resolved}, 32'd0);
         chk_cnt({tag, "_post"});
      end else begin
         i_valid = 1'b0;
         chk({tag, "_nredir"}, {31'h0, o_redirect}, 32'd0);
         chk({tag, "_nflush"}, {31'h0, o_flush},    32'd0);
      end
      chk({tag, "_busy_end"}, {31'h0, o_busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      i_rst_n = 1'b0; i_valid = 1'b0; i_funct3 = 3'b000; i_is_jump = 1'b0;
      i_br_less = 1'b0; i_br_equal = 1'b0; i_pc = 32'h0; i_target = 32'h0;
      i_pred_taken = 1'b0; i_redirect_ready = 1'b0; i_cnt_clr = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_redirect", {31'h0, o_redirect}, 32'd0);
      chk("rst_flush",    {31'h0, o_flush},    32'd0);
      chk("rst_busy",     {31'h0, o_busy},     32'd0);
      chk("rst_resolved", {31'h0, o_resolved}, 32'd0);
      chk("rst_taken",    {31'h0, o_taken},    32'd0);
      chk("rst_illegal",  {31'h0, o_illegal},  32'd0);
      chk("rst_pc",       o_redirect_pc,       32'h0);
      chk_cnt("rst");
      i_rst_n = 1'b1;

      // BEQ taken, predicted taken, accepted on the first edge after reset release.
      run_branch("beq", 3'b000, 1'b0, 32'd7, 32'd7, 32'h40, 32'h80, 1'b1, 0, 1'b0, 1'b0);
      // BLTU mispredict, fetch stalls two cycles.
      run_branch("bltu", 3'b110, 1'b0, 32'd1, 32'hF000_0000, 32'h20, 32'h100, 1'b0, 2, 1'b0, 1'b0);
      // BGE correct, then back-to-back BNE not taken at the top of memory.
      run_branch("bge", 3'b101, 1'b0, 32'd5, 32'hFFFF_FFFF, 32'h10, 32'h200, 1'b1, 0, 1'b0, 1'b0);
      run_branch("bne_wrap", 3'b001, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h300, 1'b1, 0, 1'b0, 1'b0);
      // Reserved funct3 poked while busy, then issued in IDLE.
      run_branch("poke", 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h50, 32'h60, 1'b0, 1, 1'b1, 1'b0);
      run_branch("illegal", 3'b010, 1'b0, 32'd3, 32'd3, 32'h70, 32'h90, 1'b0, 0, 1'b0, 1'b0);
      // Jump ignores funct3, even a reserved one.
      run_branch("jal", 3'b011, 1'b1, 32'd0, 32'd1, 32'h100, 32'h400, 1'b0, 0, 1'b0, 1'b0);

      // Reset in the middle of a redirect.
      i_valid = 1'b1; i_funct3 = 3'b000; i_is_jump = 1'b1; i_pred_taken = 1'b0;
      i_target = 32'h1234; i_redirect_ready = 1'b0;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_is_jump = 1'b0;
      chk("midrst_pre", {31'h0, o_redirect}, 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("midrst_redir", {31'h0, o_redirect}, 32'd0);
      chk("midrst_flush", {31'h0, o_flush},    32'd0);
      chk("midrst_pc",    o_redirect_pc,       32'h0);
      exp_br = 0; exp_mis = 0;
      chk_cnt("midrst");
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      i_redirect_ready = 1'b1;
      repeat (3) begin
         @(posedge i_clk); #1;
         chk("postrst_redir", {31'h0, o_redirect}, 32'd0);
         chk("postrst_busy",  {31'h0, o_busy},     32'd0);
      end
      i_redirect_ready = 1'b0;

      // Random branches against the operand-level model.
      for (int n = 0; n < 300; n++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         run_branch("rnd", 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                    ra, rb, {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                    1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'b0);
      end

      // Counter saturation and clear priority (counters are constant 0 when disabled).
      i_valid = 1'b1; i_is_jump = 1'b1; i_pred_taken = 1'b1; i_funct3 = 3'b000;
      repeat (65540) @(posedge i_clk);
      #1;
      i_valid = 1'b0; i_is_jump = 1'b0;
      exp_br = 65535;
      chk_cnt("sat");
      run_branch("sat_more", 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h8, 1'b1, 0, 1'b0, 1'b0);
      run_branch("clr_mis", 3'b000, 1'b0, 32'd1, 32'd2, 32'h0, 32'h8, 1'b1, 0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/br_resolver.md
BR_RESOLVER -- requirements
Module: br_resolver

Interface
REQ-001 The block SHALL have these ports: i_clk  in  1  sole clock, rising edge.
REQ-002 The block SHALL have these ports: i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 The block SHALL have these ports: i_valid  in  1  branch/jump instruction present in EX this cycle.
REQ-004 The block SHALL have these ports: i_funct3  in  3  branch condition code; i_is_jump  in  1  JAL/JALR, unconditional.
REQ-005 The block SHALL have these ports: i_br_less, i_br_equal  in  1 each  flags from the branch comparator for the current EX operands.
REQ-006 The block SHALL have these ports: o_br_un  out  1  comparator mode to the branch comparator, 1 = unsigned.
REQ-007 The block SHALL have these ports: i_pc, i_target  in  32 each  instruction PC and computed target; i_pred_taken  in  1  fetch-stage prediction.
REQ-008 The block SHALL have these ports: o_redirect  out  1  redirect request valid; i_redirect_ready  in  1  fetch accepts redirect; o_redirect_pc  out  32  corrected PC.
REQ-009 The block SHALL have these ports: o_flush  out  1  kill IF/ID contents; o_busy  out  1  resolver not in IDLE.
REQ-010 The block SHALL have these ports: o_resolved  out  1  registered one-cycle pulse per accepted instruction; o_taken  out  1  actual outcome, valid with o_resolved; o_illegal  out  1  registered pulse for a reserved funct3.
REQ-011 The block SHALL have these ports: i_cnt_clr  in  1; o_br_cnt, o_mis_cnt  out  16 each  performance counters (see Configuration).

Function
REQ-012 The block SHALL drive o_br_un = i_funct3[1] combinationally, so the comparator flags are valid in the same cycle.
REQ-013 The condition SHALL be: 000 equal; 001 not equal; 100 and 110 less; 101 and 111 not less. Codes 010 and 011 SHALL evaluate as not taken and raise o_illegal.
REQ-014 The actual outcome SHALL be: taken = i_is_jump OR condition. When i_is_jump=1, i_funct3 SHALL be ignored and o_illegal SHALL stay 0.
REQ-015 An instruction SHALL be accepted only when i_valid=1 and the state is IDLE. i_valid while o_busy=1 SHALL be ignored, with no pulse and no count.
REQ-016 On acceptance, the cycle after SHALL show o_resolved=1 and o_taken=taken.
REQ-017 A mispredict occurs when taken != i_pred_taken. On a mispredict the block SHALL latch o_redirect_pc = taken ? i_target : i_pc+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000) and move to REDIRECT.
REQ-018 The FSM SHALL have states IDLE, REDIRECT and FLUSH.
- IDLE -> REDIRECT on an accepted mispredict; otherwise remain in IDLE.
- REDIRECT: o_redirect=1 and o_flush=1, o_redirect_pc held stable. Move to FLUSH on the cycle where i_redirect_ready=1.
- FLUSH: o_redirect=0 and o_flush=1 for exactly one cycle, then IDLE.
REQ-019 o_busy SHALL be 1 in REDIRECT and FLUSH, and 0 in IDLE.
REQ-020 If i_redirect_ready=1 on the first REDIRECT cycle, REDIRECT SHALL last one cycle. Minimum mispredict penalty: 3 cycles from acceptance to IDLE.
REQ-021 A correctly predicted instruction SHALL cause no redirect and no flush, and o_busy SHALL stay 0.

Reset
REQ-022 While i_rst_n=0 the block SHALL hold: state IDLE; o_redirect, o_flush, o_busy, o_resolved, o_taken, o_illegal = 0; o_redirect_pc = 0x00000000; counters = 0.
REQ-023 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abandon the redirect immediately; no redirect SHALL be issued after release.
REQ-024 The first acceptance SHALL be possible on the first rising edge after i_rst_n deasserts.

Configuration
REQ-025 With BR_PERF_CNT_EN defined:
- o_br_cnt SHALL increment on every accepted instruction.
- o_mis_cnt SHALL increment on every accepted mispredict.
- Both counters SHALL saturate at 0xFFFF.
- i_cnt_clr SHALL zero both counters synchronously, taking priority over a simultaneous increment.
REQ-026 Without BR_PERF_CNT_EN, the ports SHALL remain, o_br_cnt and o_mis_cnt SHALL be constant 0, i_cnt_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-027 BEQ with i_br_equal=1, i_pred_taken=1 -> o_resolved=1, o_taken=1 next cycle; o_redirect, o_flush and o_busy stay 0.
REQ-028 BLTU with i_pred_taken=0, i_br_less=1, i_target=0x00000100, i_redirect_ready=0 for 2 cycles then 1 -> o_br_un=1 in the acceptance cycle; o_redirect=1 with o_redirect_pc=0x00000100 for 3 cycles; then one FLUSH cycle; then IDLE.
REQ-029 BGE with i_br_less=0, i_pred_taken=1 (correctly predicted), followed one cycle later by BNE with i_br_equal=1, i_pred_taken=1, i_pc=0xFFFFFFFC -> BNE not taken; o_redirect_pc=0x00000000 (wrap).
REQ-030 i_valid=1 during REDIRECT with i_funct3=010 -> ignored: no o_illegal, no o_resolved, counters unchanged. The same instruction in IDLE -> o_illegal=1, o_taken=0.
REQ-031 i_rst_n pulled low during REDIRECT -> o_redirect and o_flush drop to 0 asynchronously; state IDLE after release.
REQ-032 With BR_PERF_CNT_EN: preload o_br_cnt=0xFFFF, accept a branch -> o_br_cnt stays 0xFFFF. i_cnt_clr together with an accepted mispredict -> both counters 0.
